led_strip_multi: RTL and testbench

LED_STRIP_MULTI -- requirements
Module: led_strip_multi

---
 rtl/led_strip_multi.sv | 162 ++++++++++++++++
 tb/tb_led_strip_multi.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_strip_multi.sv
// Multi-channel serial LED strip driver: register frame buffer, one shared bit/byte
// timer, and a per-channel lane that turns the current bit into a high/low pulse.
`timescale 1ns/1ps

module led_strip_lane #(
   parameter int T0H_CYC = 4,
   parameter int T1H_CYC = 8,
   parameter int CW      = 4
) (
   input  logic          active,
   input  logic [7:0]    data,
   input  logic [2:0]    bit_idx,
   input  logic [CW-1:0] cyc,
   output logic          led
);
   logic          bit_val;
   logic [CW-1:0] high_len;

   // bit_idx counts up while the byte goes out MSB first
   assign bit_val  = data[3'd7 - bit_idx];
   assign high_len = bit_val ? CW'(T1H_CYC) : CW'(T0H_CYC);
   assign led      = active && (cyc < high_len);
endmodule

module led_strip_multi #(
   parameter int CHANNELS = 2,
   parameter int LED_CNT  = 11,
   parameter int BPL      = 3,
   parameter int T0H_CYC  = 4,
   parameter int T1H_CYC  = 8,
   parameter int TBIT_CYC = 12,
   parameter int TRES_CYC = 500
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                wr_en,
   input  logic [9:0]          wr_addr,
   input  logic [7:0]          wr_data,
   input  logic                update,
   output logic                busy,
   output logic                wr_err,
   output logic [CHANNELS-1:0] led_o
);
   localparam int NB    = LED_CNT * BPL;
   localparam int TOTAL = CHANNELS * NB;
   localparam int AW    = $clog2(TOTAL);
   localparam int BW    = (NB > 1) ? $clog2(NB) : 1;
   localparam int CMAX  = (TBIT_CYC > TRES_CYC) ? TBIT_CYC : TRES_CYC;
   localparam int CW    = $clog2(CMAX + 1);

   typedef enum logic [1:0] {IDLE, SEND, LATCH} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cyc, cyc_nxt;
   logic [2:0]    bit_idx, bit_nxt;
   logic [BW-1:0] byte_idx, byte_nxt;
   logic          pend, pend_nxt;
   logic          wr_ok;
   logic          sending;
   logic [7:0]    fb [TOTAL];

   assign busy    = (state != IDLE);
   assign sending = (state == SEND);
   assign wr_ok   = wr_en && (state == IDLE) && ({1'b0, wr_addr} < 11'(TOTAL));

   always_comb begin
      state_nxt = state;
      cyc_nxt   = cyc;
      bit_nxt   = bit_idx;
      byte_nxt  = byte_idx;
      pend_nxt  = pend;
      unique case (state)
         IDLE: begin
            if (update) begin
               state_nxt = SEND;
               cyc_nxt   = '0;
               bit_nxt   = '0;
               byte_nxt  = '0;
            end
         end
         SEND: begin
            if (update) pend_nxt = 1'b1;
            if (cyc == CW'(TBIT_CYC - 1)) begin
               cyc_nxt = '0;
               if (bit_idx == 3'd7) begin
                  bit_nxt = '0;
                  if (byte_idx == BW'(NB - 1)) begin
                     byte_nxt  = '0;
                     state_nxt = LATCH;
                  end else begin
                     byte_nxt = byte_idx + 1'b1;
                  end
               end else begin
                  bit_nxt = bit_idx + 1'b1;
               end
            end else begin
               cyc_nxt = cyc + 1'b1;
            end
         end
         LATCH: begin
            if (update) pend_nxt = 1'b1;
            if (cyc == CW'(TRES_CYC - 1)) begin
               cyc_nxt = '0;
               // an update landing in the final gap cycle still counts as pending
               if (pend || update) begin
                  state_nxt = SEND;
                  pend_nxt  = 1'b0;
               end else begin
                  state_nxt = IDLE;
               end
            end else begin
               cyc_nxt = cyc + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         cyc      <= '0;
         bit_idx  <= '0;
         byte_idx <= '0;
         pend     <= 1'b0;
         wr_err   <= 1'b0;
      end else begin
         state    <= state_nxt;
         cyc      <= cyc_nxt;
         bit_idx  <= bit_nxt;
         byte_idx <= byte_nxt;
         pend     <= pend_nxt;
         wr_err   <= wr_en && !wr_ok;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < TOTAL; i++) fb[i] <= 8'h00;
      end else if (wr_ok) begin
         fb[wr_addr[AW-1:0]] <= wr_data;
      end
   end

   // every channel reads its own slice of the buffer with the shared byte index
   for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
      logic [AW-1:0] rd_idx;
      assign rd_idx = AW'(c * NB) + AW'(byte_idx);

      led_strip_lane #(
         .T0H_CYC (T0H_CYC),
         .T1H_CYC (T1H_CYC),
         .CW      (CW)
      ) u_lane (
         .active  (sending),
         .data    (fb[rd_idx]),
         .bit_idx (bit_idx),
         .cyc     (cyc),
         .led     (led_o[c])
      );
   end
endmodule

// File: tb/tb_led_strip_multi.sv
// Bench for led_strip_multi: queue-based waveform model checked every cycle, plus
// directed frames whose pulse widths and busy lengths are pinned by hand.
`timescale 1ns/1ps

module tb_led_strip_multi;
   localparam int CH = 2, LC = 2, BP = 3, T0 = 2, T1 = 4, TB = 6, TR = 20;
   localparam int NB = LC * BP, TOT = CH * NB;

   logic          clk = 1'b0, reset = 1'b1, wr_en = 1'b0, update = 1'b0;
   logic [9:0]    wr_addr = '0;
   logic [7:0]    wr_data = '0;
   logic          busy, wr_err;
   logic [CH-1:0] led_o;

   led_strip_multi #(
      .CHANNELS (CH), .LED_CNT (LC), .BPL (BP),
      .T0H_CYC (T0), .T1H_CYC (T1), .TBIT_CYC (TB), .TRES_CYC (TR)
   ) dut (
      .clk (clk), .reset (reset), .wr_en (wr_en), .wr_addr (wr_addr),
      .wr_data (wr_data), .update (update), .busy (busy), .wr_err (wr_err),
      .led_o (led_o)
   );

   always #5 clk = ~clk;

   int total = 0, bad = 0;

   logic [7:0]    mem [TOT];
   logic [CH-1:0] exp_q [$];
   bit            pend, exp_err, inited, was_busy;
   int            busy_run, last_busy_len;
   int            hi_cnt [CH];
   int            pq0 [$], pq1 [$];

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // expected per-cycle led vector for a whole frame followed by its latch gap
   function automatic void push_frame();
      logic [CH-1:0] v;
      for (int b = 0; b < NB; b++)
         for (int k = 7; k >= 0; k--)
            for (int t = 0; t < TB; t++) begin
               for (int c = 0; c < CH; c++) v[c] = (t < (mem[c*NB+b][k] ? T1 : T0));
               exp_q.push_back(v);
            end
      for (int t = 0; t < TR; t++) exp_q.push_back('0);
   endfunction

   // mid-cycle: compare, record pulses, then advance the model over the coming edge
   initial forever begin
      @(negedge clk);
      if (inited) begin
         chk("busy", int'(busy), int'(exp_q.size() != 0));
         chk("led_o", int'(led_o), (exp_q.size() != 0) ? int'(exp_q[0]) : 0);
         chk("wr_err", int'(wr_err), int'(exp_err));
      end
      if (busy) busy_run++;
      else if (busy_run > 0) begin
         last_busy_len = busy_run;
         busy_run = 0;
      end
      for (int c = 0; c < CH; c++) begin
         if (led_o[c]) hi_cnt[c]++;
         else if (hi_cnt[c] > 0) begin
            if (c == 0) pq0.push_back(hi_cnt[c]);
            else        pq1.push_back(hi_cnt[c]);
            hi_cnt[c] = 0;
         end
      end
      if (reset) begin
         foreach (mem[i]) mem[i] = 8'h00;
         exp_q.delete();
         pend    = 1'b0;
         exp_err = 1'b0;
         inited  = 1'b1;
      end else if (inited) begin
         was_busy = (exp_q.size() != 0);
         exp_err  = wr_en && (was_busy || int'(wr_addr) >= TOT);
         if (wr_en && !was_busy && int'(wr_addr) < TOT) mem[wr_addr] = wr_data;
         if (was_busy) begin
            if (update) pend = 1'b1;
            void'(exp_q.pop_front());
            if (exp_q.size() == 0 && pend) begin
               push_frame();
               pend = 1'b0;
            end
         end else if (update) begin
            push_frame();
         end
      end
   end

   task automatic cyc1();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int a, input int d);
      wr_en = 1'b1; wr_addr = 10'(a); wr_data = 8'(d);
      cyc1();
      wr_en = 1'b0;
   endtask

   task automatic upd();
      update = 1'b1;
      cyc1();
      update = 1'b0;
   endtask

   task automatic wait_idle(input int lim);
      int n = 0;
      while (busy && n < lim) begin
         cyc1();
         n++;
      end
      chk("idle_timeout", int'(busy), 0);
      cyc1();
   endtask

   task automatic clear_pulses();
      pq0.delete();
      pq1.delete();
   endtask

   initial begin
      logic [7:0] pat [7];
      pat = '{8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'hFF};

      repeat (3) cyc1();
      reset = 1'b0;
      chk("rst_busy", int'(busy), 0);
      chk("rst_led", int'(led_o), 0);
      chk("rst_err", int'(wr_err), 0);

      // basic frame: 0x80..0x01 on channel 0, 0xFF first on channel 1
      for (int i = 0; i < 7; i++) wr(i, int'(pat[i]));
      clear_pulses();
      upd();
      wait_idle(1000);
      chk("f1_len", last_busy_len, 308);
      chk("f1_np0", pq0.size(), 48);
      chk("f1_np1", pq1.size(), 48);
      for (int i = 0; i < pq0.size() && i < 48; i++)
         chk("f1_ch0_bit", pq0[i], (i == 0 || i == 47) ? 4 : 2);
      for (int i = 0; i < pq1.size() && i < 8; i++)
         chk("f1_ch1_bit", pq1[i], 4);

      // out-of-range write is rejected
      wr(12, 8'hAA);
      chk("oor_err", int'(wr_err), 1);
      cyc1();
      chk("oor_err_clr", int'(wr_err), 0);
      upd();
      wait_idle(1000);

      // write while busy is rejected and old byte is resent
      upd();
      repeat (5) cyc1();
      wr(0, 8'h00);
      chk("busy_err", int'(wr_err), 1);
      wait_idle(1000);
      clear_pulses();
      upd();
      wait_idle(1000);
      chk("old_byte", (pq0.size() > 0) ? pq0[0] : -1, 4);

      // two updates during SEND collapse into one extra frame
      upd();
      repeat (10) cyc1();
      upd();
      repeat (40) cyc1();
      upd();
      wait_idle(2000);
      chk("dbl_len", last_busy_len, 616);

      // reset mid-frame aborts and clears the buffer
      upd();
      repeat (99) cyc1();
      reset = 1'b1;
      cyc1();
      reset = 1'b0;
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_led", int'(led_o), 0);
      cyc1();
      clear_pulses();
      upd();
      wait_idle(1000);
      chk("zero_np0", pq0.size(), 48);
      chk("zero_np1", pq1.size(), 48);
      for (int i = 0; i < pq0.size() && i < 48; i++) chk("zero_ch0", pq0[i], 2);
      for (int i = 0; i < pq1.size() && i < 48; i++) chk("zero_ch1", pq1[i], 2);

      // write and update together: new byte makes it into the frame
      clear_pulses();
      wr_en = 1'b1; wr_addr = 10'd0; wr_data = 8'hFF; update = 1'b1;
      cyc1();
      wr_en = 1'b0; update = 1'b0;
      wait_idle(1000);
      for (int i = 0; i < pq0.size() && i < 9; i++)
         chk("same_cyc", pq0[i], (i < 8) ? 4 : 2);

      // random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         wr_en   = ($urandom_range(0, 99) < 30);
         wr_addr = ($urandom_range(0, 19) == 0) ? 10'h3FF : 10'($urandom_range(0, 15));
         wr_data = 8'($urandom);
         update  = ($urandom_range(0, 99) < 2);
         reset   = ($urandom_range(0, 999) < 2);
         cyc1();
      end
      wr_en = 1'b0; update = 1'b0; reset = 1'b0;
      wait_idle(2000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
